ws2812b_bit_encoder: RTL and testbench

//   Serialises one 24-bit GRB pixel word per valid/ready handshake into the WS2812B one-wire
//   NRZ waveform on a single output pin. Sits directly downstream of the TinyQV ledstrip

---
 rtl/ws2812b_bit_encoder_if.sv | 11 +
 rtl/ws2812b_bit_encoder.sv | 109 ++++++++++
 tb/tb_ws2812b_bit_encoder.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812b_bit_encoder_if.sv
// Pixel stream handshake between the ledstrip peripheral (master) and the
// WS2812B bit encoder (slave).
interface ws2812b_bit_encoder_if;
  logic [23:0] data_in;
  logic        valid;
  logic        latch;
  logic        ready;

  modport master (output data_in, output valid, output latch, input ready);
  modport slave  (input data_in, input valid, input latch, output ready);
endinterface

// File: rtl/ws2812b_bit_encoder.sv
// Serialises one 24-bit GRB pixel per handshake into the WS2812B NRZ waveform,
// optionally followed by the strip reset (latch) low period.
//
// state | meaning
// IDLE  | waiting for a pixel, led low, ready high
// HIGH  | high part of the current bit (T0H or T1H cycles)
// LOW   | low remainder of the current bit period
// LATCH | strip reset low period after the last bit of a latched pixel
module ws2812b_bit_encoder #(
  parameter int CLOCK_MHZ = 64,
  parameter int T0H_NS    = 400,
  parameter int T1H_NS    = 800,
  parameter int BIT_NS    = 1250,
  parameter int RESET_US  = 300
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ws2812b_bit_encoder_if.slave   bus,
  output logic                   led
);

  localparam int T0H_CYC   = CLOCK_MHZ * T0H_NS / 1000;
  localparam int T1H_CYC   = CLOCK_MHZ * T1H_NS / 1000;
  localparam int BIT_CYC   = CLOCK_MHZ * BIT_NS / 1000;
  localparam int RESET_CYC = CLOCK_MHZ * RESET_US;
  localparam int MAX_CYC   = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
  localparam int TICK_W    = $clog2(MAX_CYC + 1);

  localparam logic [TICK_W-1:0] T0H_T   = TICK_W'(T0H_CYC);
  localparam logic [TICK_W-1:0] T1H_T   = TICK_W'(T1H_CYC);
  localparam logic [TICK_W-1:0] BIT_T   = TICK_W'(BIT_CYC);
  localparam logic [TICK_W-1:0] RESET_T = TICK_W'(RESET_CYC);
  localparam logic [TICK_W-1:0] ONE_T   = TICK_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [TICK_W-1:0] tick;
  logic [TICK_W-1:0] th;
  logic [4:0]        bit_cnt;
  logic [23:0]       shreg;
  logic              latch_q;
  logic              accept;
  logic              next_bit;

  assign bus.ready = (state == IDLE);
  assign accept    = bus.valid & (state == IDLE);
  assign th        = shreg[23] ? T1H_T : T0H_T;

  always_comb begin
    state_d  = state;
    next_bit = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_d = HIGH;
      end
      HIGH: begin
        if (tick == th - ONE_T) state_d = LOW;
      end
      LOW: begin
        if (tick == BIT_T - th - ONE_T) begin
          if (bit_cnt != 5'd0) begin
            next_bit = 1'b1;
            state_d  = HIGH;
          end else if (latch_q) begin
            state_d = LATCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      LATCH: begin
        if (tick == RESET_T - ONE_T) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // led follows the next state so the pin is a clean flop output aligned with the phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      led     <= 1'b0;
      tick    <= '0;
      bit_cnt <= 5'd0;
      shreg   <= 24'd0;
      latch_q <= 1'b0;
    end else begin
      state <= state_d;
      led   <= (state_d == HIGH);
      if ((state_d != state) || (state == IDLE)) tick <= '0;
      else                                       tick <= tick + ONE_T;
      if (accept) begin
        shreg   <= bus.data_in;
        latch_q <= bus.latch;
        bit_cnt <= 5'd23;
      end else if (next_bit) begin
        shreg   <= {shreg[22:0], 1'b0};
        bit_cnt <= bit_cnt - 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_ws2812b_bit_encoder.sv
// Self-checking bench for ws2812b_bit_encoder: a led monitor measures high widths,
// bit periods and trailing low time, compared against widths derived from pixel bits.
module tb_ws2812b_bit_encoder;

  localparam int T0H = 25;
  localparam int T1H = 51;
  localparam int BIT = 80;
  localparam int RST = 19200;

  logic clk = 1'b0;
  logic rst_n;
  logic led;
  int   tests = 0;
  int   fails = 0;

  ws2812b_bit_encoder_if bus ();

  ws2812b_bit_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .led   (led)
  );

  always #5 clk = ~clk;

  // led monitor, sampled on the falling edge
  int mon_cyc = 0, hi_run = 0, lo_run = 0, last_rise = 0, first_rise = -1;
  bit rise_seen = 1'b0, led_q = 1'b0;
  int highs[$];
  int periods[$];

  always @(negedge clk) begin
    mon_cyc++;
    if (led === 1'b1) begin
      if (!led_q) begin
        if (rise_seen) periods.push_back(mon_cyc - last_rise);
        else           first_rise = mon_cyc;
        rise_seen = 1'b1;
        last_rise = mon_cyc;
        hi_run    = 0;
      end
      hi_run++;
      led_q = 1'b1;
    end else begin
      if (led_q) begin
        highs.push_back(hi_run);
        lo_run = 0;
      end
      lo_run++;
      led_q = 1'b0;
    end
  end

  task automatic clr_mon();
    highs.delete();
    periods.delete();
    rise_seen  = 1'b0;
    hi_run     = 0;
    lo_run     = 0;
    first_rise = -1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_period(input string tag, input int idx, input int p);
    tests++;
    assert (p >= BIT && p <= BIT + 3) else begin
      fails++;
      $error("FAIL %s/period%0d: observed %0d expected %0d..%0d", tag, idx, p, BIT, BIT + 3);
    end
  endtask

  // one pixel through the handshake; inj>0 pulses valid with FFFFFF that many cycles in
  task automatic run_pixel(input string tag, input logic [23:0] d, input bit lat, input int inj);
    int n, nexp, lim, acc;
    int exp_h[$];
    clr_mon();
    for (int i = 23; i >= 0; i--) exp_h.push_back(d[i] ? T1H : T0H);
    nexp = 24 * BIT + (lat ? RST : 0);
    lim  = nexp + 50;
    @(negedge clk); #1;
    chk({tag, "/ready_pre"}, int'(bus.ready), 1);
    bus.data_in = d;
    bus.latch   = lat;
    bus.valid   = 1'b1;
    @(posedge clk);
    acc = mon_cyc;
    #1;
    bus.valid = 1'b0;
    bus.latch = 1'b0;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
      if (inj > 0 && n == inj) begin
        bus.data_in = 24'hFFFFFF;
        bus.valid   = 1'b1;
      end else if (inj > 0 && n == inj + 1) begin
        bus.valid = 1'b0;
      end
    end while (!bus.ready && n < lim);
    chk({tag, "/ready_cycles"}, n, nexp + 1);
    chk({tag, "/first_rise"}, first_rise, acc + 1);
    chk({tag, "/n_highs"}, highs.size(), 24);
    for (int i = 0; i < 24; i++)
      chk($sformatf("%s/high%0d", tag, i), (i < highs.size()) ? highs[i] : -1, exp_h[i]);
    chk({tag, "/n_periods"}, periods.size(), 23);
    for (int i = 0; i < periods.size(); i++)
      chk($sformatf("%s/period%0d", tag, i), periods[i], BIT);
    chk({tag, "/tail_low"}, lo_run, BIT - exp_h[23] + (lat ? RST : 0) + 1);
  endtask

  // ledstrip peripheral model: holds valid until accepted, latch on the last pixel
  task automatic periph_frame(input int count);
    int n, lim;
    logic [23:0] d;
    int exp_h[$];
    clr_mon();
    for (int p = 0; p < count; p++) begin
      d = 24'($urandom);
      for (int i = 23; i >= 0; i--) exp_h.push_back(d[i] ? T1H : T0H);
      @(negedge clk);
      bus.data_in = d;
      bus.latch   = (p == count - 1);
      bus.valid   = 1'b1;
      n = 0;
      while (!bus.ready && n < 2100) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("p6/accept%0d", p), int'(bus.ready), 1);
      @(posedge clk); #1;
      bus.valid = 1'b0;
      bus.latch = 1'b0;
    end
    lim = 24 * BIT + RST + 50;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!bus.ready && n < lim);
    chk("p6/ready_cycles", n, 24 * BIT + RST + 1);
    chk("p6/ready_end", int'(bus.ready), 1);
    chk("p6/n_highs", highs.size(), 24 * count);
    for (int i = 0; i < 24 * count; i++)
      chk($sformatf("p6/high%0d", i), (i < highs.size()) ? highs[i] : -1, exp_h[i]);
    chk("p6/n_periods", periods.size(), 24 * count - 1);
    for (int i = 0; i < periods.size(); i++) chk_period("p6", i, periods[i]);
    chk("p6/tail_low", lo_run, BIT - exp_h[24 * count - 1] + RST + 1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ones;
    rst_n       = 1'b1;
    bus.data_in = 24'd0;
    bus.valid   = 1'b0;
    bus.latch   = 1'b0;

    // reset acts without a clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("t1/led_rst", int'(led), 0);
    chk("t1/ready_rst", int'(bus.ready), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ones = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (led !== 1'b0) ones++;
    end
    chk("t1/idle_led_high_cycles", ones, 0);
    chk("t1/idle_ready", int'(bus.ready), 1);

    run_pixel("t2", 24'hA500FF, 1'b0, 0);
    run_pixel("t3", 24'hA500FF, 1'b1, 0);

    // mid-pixel valid is ignored, nothing follows the first pixel
    run_pixel("t4", 24'hA500FF, 1'b0, 500);
    ones = 0;
    repeat (200) begin
      @(negedge clk); #1;
      if (led !== 1'b0) ones++;
    end
    chk("t4/no_second_pixel", ones, 0);
    chk("t4/n_highs_after", highs.size(), 24);

    // reset during the high phase of bit 10
    clr_mon();
    @(negedge clk);
    bus.data_in = 24'hA500FF;
    bus.valid   = 1'b1;
    @(posedge clk); #1;
    bus.valid = 1'b0;
    repeat (10 * BIT + 5) @(negedge clk);
    #1;
    chk("t5/led_before_rst", int'(led), 1);
    rst_n = 1'b0;
    #1;
    chk("t5/led_rst", int'(led), 0);
    chk("t5/ready_rst", int'(bus.ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ones = 0;
    repeat (30) begin
      @(negedge clk); #1;
      if (led !== 1'b0) ones++;
    end
    chk("t5/idle_after_rst", ones, 0);
    chk("t5/ready_after_rst", int'(bus.ready), 1);
    run_pixel("t5", 24'h000001, 1'b0, 0);

    for (int r = 0; r < 4; r++)
      run_pixel($sformatf("rnd%0d", r), 24'($urandom), 1'b0, 0);

    periph_frame(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
